// File: rtl/sr_latch_ctrl_if.sv
// Signal bundle between a set/reset requester and the SR latch sequencer.
// The master side owns requests and latch read-back; the slave side is the sequencer.
interface sr_latch_ctrl_if;
  logic set_req;
  logic rst_req;
  logic q;
  logic not_q;
  logic en;
  logic s;
  logic r;
  logic ack;
  logic err;
  logic busy;
  logic last_op;

  modport master (
    output set_req, rst_req, q, not_q,
    input  en, s, r, ack, err, busy, last_op
  );

  modport slave (
    input  set_req, rst_req, q, not_q,
    output en, s, r, ack, err, busy, last_op
  );
endinterface

// File: rtl/sr_latch_ctrl.sv
// Sequences glitch-free write cycles (setup, enable pulse, hold, read-back) into one
// gated SR latch, arbitrating set/reset requests and flagging read-back mismatches.
module sr_latch_ctrl #(
  parameter int unsigned SetupCycles = 1,
  parameter int unsigned PulseCycles = 2,
  parameter int unsigned HoldCycles  = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  sr_latch_ctrl_if.slave io_bus
);

  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StCheck} state_e;

  localparam logic [7:0] SetupLoad = 8'(SetupCycles - 1);
  localparam logic [7:0] PulseLoad = 8'(PulseCycles - 1);
  localparam logic [7:0] HoldLoad  = 8'(HoldCycles - 1);

  state_e     r_state;
  logic [7:0] r_cnt;
  logic       r_op;
  logic       r_last_op;
  logic       r_en;
  logic       r_s;
  logic       r_r;
  logic       r_ack;
  logic       r_err;
  logic       r_busy;

  logic       w_any_req;
  logic       w_grant_op;
  logic [1:0] w_expect;
  logic       w_readback_bad;

  always_comb begin
    w_any_req  = io_bus.set_req | io_bus.rst_req;
    // On a tie, alternate away from the previous operation.
    w_grant_op = (io_bus.set_req & io_bus.rst_req) ? ~r_last_op : io_bus.set_req;
    w_expect   = r_op ? 2'b10 : 2'b01;
    // Case inequality so an undriven or X latch output also counts as a failure.
    w_readback_bad = ({io_bus.q, io_bus.not_q} !== w_expect);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_op      <= 1'b0;
      r_last_op <= 1'b1;
      r_en      <= 1'b0;
      r_s       <= 1'b0;
      r_r       <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_state   <= StSetup;
            r_cnt     <= SetupLoad;
            r_op      <= w_grant_op;
            r_last_op <= w_grant_op;
            r_err     <= 1'b0;
            r_s       <= w_grant_op;
            r_r       <= ~w_grant_op;
            r_busy    <= 1'b1;
          end
        end
        StSetup: begin
          if (r_cnt == 8'd0) begin
            r_state <= StPulse;
            r_cnt   <= PulseLoad;
            r_en    <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        StPulse: begin
          if (r_cnt == 8'd0) begin
            r_state <= StHold;
            r_cnt   <= HoldLoad;
            r_en    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        StHold: begin
          if (r_cnt == 8'd0) begin
            r_state <= StCheck;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_ack   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        StCheck: begin
          r_state <= StIdle;
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
          r_err   <= w_readback_bad;
        end
        default: begin
          r_state <= StIdle;
          r_en    <= 1'b0;
          r_s     <= 1'b0;
          r_r     <= 1'b0;
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.en      = r_en;
  assign io_bus.s       = r_s;
  assign io_bus.r       = r_r;
  assign io_bus.ack     = r_ack;
  assign io_bus.err     = r_err;
  assign io_bus.busy    = r_busy;
  assign io_bus.last_op = r_last_op;

endmodule
